// File: rtl/skew_loader.sv
// skew_loader: fetches a 16-lane int8 tile from 64-bit memory and writes it diagonally skewed into SRAM.
// Optional: define SKEW_LOADER_WORD_CACHE_EN for a per-lane word cache that skips redundant reads.
module skew_loader #(
   parameter int N         = 16,
   parameter int K         = 512,
   parameter int ROW_WORDS = 64,
   parameter int SRAM_AW   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [5:0]         tile_idx,
   input  logic [15:0]        base_addr,
   output logic [15:0]        mem_addr,
   output logic               mem_read_enb,
   input  logic [63:0]        mem_data,
   output logic               sram_we,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [N*8-1:0]     sram_din,
   output logic               busy,
   output logic               done
);
   localparam int LW = $clog2(N);
   localparam logic [SRAM_AW-1:0] LAST_A = SRAM_AW'(K + N - 2);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_DONE} state_t;
   typedef struct packed {
      logic        valid;
      logic [15:0] addr;
      logic [2:0]  byte_sel;
   } lane_t;

   state_t             state;
   logic [SRAM_AW-1:0] a, nxt_a;
   logic [LW-1:0]      l, nxt_l;
   logic               mode_q, src_mode;
   logic [5:0]         tile_q, src_tile;
   logic [15:0]        base_q, src_base;
   logic [N*8-1:0]     asm_q, asm_nx;
   logic               lane_vld_q;
   logic [2:0]         lane_sel_q;
   logic [63:0]        src_word;
   logic [7:0]         lane_byte;
   logic               go_lane;
   lane_t              nxt;

`ifdef SKEW_LOADER_WORD_CACHE_EN
   logic [63:0] cache_word [N];
   logic [15:0] cache_addr [N];
   logic [N-1:0] cache_vld;
   logic         fetch_q;
   logic         hit;
`endif

   // Element k = a - l of lane l; address and byte lane depend on whether lanes are rows or columns.
   function automatic lane_t decode(input logic [SRAM_AW-1:0] wa, input logic [LW-1:0] wl,
                                    input logic m, input logic [5:0] t, input logic [15:0] b);
      lane_t       r;
      logic [15:0] k, c;
      k = 16'(wa) - 16'(wl);
      c = 16'(t) * 16'(N) + 16'(wl);
      r.valid = (16'(wa) >= 16'(wl)) && (k <= 16'(K - 1));
      if (!m) begin
         r.addr     = b + c * 16'(ROW_WORDS) + (k >> 3);
         r.byte_sel = ~k[2:0];
      end else begin
         r.addr     = b + k * 16'(ROW_WORDS) + (c >> 3);
         r.byte_sel = ~c[2:0];
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      nxt_a    = a;
      nxt_l    = l;
      src_mode = mode_q;
      src_tile = tile_q;
      src_base = base_q;
      case (state)
         S_IDLE: begin
            nxt_a    = '0;
            nxt_l    = '0;
            src_mode = mode;
            src_tile = tile_idx;
            src_base = base_addr;
         end
         S_DATA:  nxt_l = l + 1'b1;
         S_WRITE: begin
            nxt_a = a + 1'b1;
            nxt_l = '0;
         end
         default: ;
      endcase
      nxt     = decode(nxt_a, nxt_l, src_mode, src_tile, src_base);
      go_lane = (state == S_IDLE && start) || (state == S_DATA && l != LW'(N - 1)) ||
                (state == S_WRITE && a != LAST_A);

      src_word = mem_data;
`ifdef SKEW_LOADER_WORD_CACHE_EN
      if (!fetch_q) src_word = cache_word[l];
      hit = (state != S_IDLE) && nxt.valid && cache_vld[nxt_l] && (cache_addr[nxt_l] == nxt.addr);
`endif
      lane_byte = lane_vld_q ? src_word[{lane_sel_q, 3'b000} +: 8] : 8'h00;
      asm_nx    = asm_q;
      asm_nx[{l, 3'b000} +: 8] = lane_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         a            <= '0;
         l            <= '0;
         mode_q       <= 1'b0;
         tile_q       <= '0;
         base_q       <= '0;
         asm_q        <= '0;
         lane_vld_q   <= 1'b0;
         lane_sel_q   <= '0;
         mem_addr     <= '0;
         mem_read_enb <= 1'b1;
         sram_we      <= 1'b0;
         sram_addr    <= '0;
         sram_din     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef SKEW_LOADER_WORD_CACHE_EN
         fetch_q      <= 1'b0;
         cache_vld    <= '0;
`endif
      end else begin
         sram_we      <= 1'b0;
         done         <= 1'b0;
         mem_read_enb <= 1'b1;
         case (state)
            S_IDLE: if (start) begin
               mode_q <= mode;
               tile_q <= tile_idx;
               base_q <= base_addr;
               busy   <= 1'b1;
`ifdef SKEW_LOADER_WORD_CACHE_EN
               cache_vld <= '0;
`endif
            end
            S_ADDR: state <= S_DATA;
            S_DATA: begin
               asm_q <= asm_nx;
`ifdef SKEW_LOADER_WORD_CACHE_EN
               if (fetch_q) cache_vld[l] <= 1'b1;
`endif
               if (l == LW'(N - 1)) begin
                  state     <= S_WRITE;
                  sram_we   <= 1'b1;
                  sram_addr <= a;
                  sram_din  <= asm_nx;
                  asm_q     <= '0;
               end
            end
            S_WRITE: if (a == LAST_A) begin
               state <= S_DONE;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // Entering a new lane overrides the case transitions above.
         if (go_lane) begin
            a          <= nxt_a;
            l          <= nxt_l;
            lane_vld_q <= nxt.valid;
            lane_sel_q <= nxt.byte_sel;
`ifdef SKEW_LOADER_WORD_CACHE_EN
            if (nxt.valid && !hit) begin
               state        <= S_ADDR;
               fetch_q      <= 1'b1;
               mem_addr     <= nxt.addr;
               mem_read_enb <= 1'b0;
            end else begin
               state   <= S_DATA;
               fetch_q <= 1'b0;
            end
`else
            state <= S_ADDR;
            if (nxt.valid) begin
               mem_addr     <= nxt.addr;
               mem_read_enb <= 1'b0;
            end
`endif
         end
      end
   end

`ifdef SKEW_LOADER_WORD_CACHE_EN
   // NOTE: cache storage has no reset; cache_vld alone decides whether an entry is usable.
   always_ff @(posedge clk) begin
      if (state == S_DATA && fetch_q) begin
         cache_word[l] <= mem_data;
         cache_addr[l] <= mem_addr;
      end
   end
`endif
endmodule

// File: doc/skew_loader.md
Name: skew_loader

Overview:
- Upstream feeder for the systolic-array SRAM banks.
- Fetches one 16-lane int8 operand tile from 64-bit main memory and writes it into a 128-bit-wide SRAM in diagonally skewed order: lane l of SRAM word a holds element k = a - l.
- The array can then stream SRAM words in address order, with no further alignment logic.
- One instance loads the A bank (row-major tile), another loads the B bank (column tile), selected by `mode`.

Parameters:
- N, 16: lanes per SRAM word (8 bits each).
- K, 512: reduction depth (elements per lane).
- ROW_WORDS, 64: 64-bit memory words per matrix row.
- SRAM_AW, 10: SRAM address width.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous reset, active-high.
- start  in  1: one-cycle request; sampled only in IDLE.
- mode  in  1: 0 = A tile (lane = matrix row), 1 = B tile (lane = matrix column).
- tile_idx  in  6: tile number; lane l maps to matrix row/column tile_idx*N + l.
- base_addr  in  16: memory base of the matrix.
- mem_addr  out  16: memory word address.
- mem_read_enb  out  1: active-low read strobe.
- mem_data  in  64: read data, valid the cycle after the address cycle.
- sram_we  out  1: SRAM write strobe, active-high, one cycle per word.
- sram_addr  out  SRAM_AW: SRAM write address.
- sram_din  out  N*8: skewed word; lane l occupies bits [8l+7:8l].
- busy  out  1: high from the cycle after start until done.
- done  out  1: one-cycle completion pulse.

Behaviour:
- Reset: all outputs are 0 except mem_read_enb = 1; state is IDLE.
  - rst mid-operation aborts immediately. No further SRAM writes occur; the partial SRAM contents are undefined to the consumer.
- Word range: a = 0 .. K+N-2 (527 words for the defaults).
- Lane validity: lane l of word a is valid iff 0 <= a-l <= K-1. Invalid lanes write 0x00.
- Element location for k = a-l and c = tile_idx*N + l (all arithmetic 16-bit, wrapping):
  - mode 0: address base_addr + c*ROW_WORDS + k/8; byte lane 7-(k%8).
  - mode 1: address base_addr + k*ROW_WORDS + c/8; byte lane 7-(c%8).
  - Byte lane j means mem_data[8j+7:8j], so byte 0 of a word is the MSB.
- States:
  - IDLE: on start, latch mode/tile_idx/base_addr, set a=0, l=0 -> ADDR.
  - ADDR: if lane valid, drive mem_addr and mem_read_enb=0; otherwise keep mem_read_enb=1 and mem_addr unchanged. -> DATA.
  - DATA: mem_read_enb=1; place the selected byte (or 0) into lane l of the assembly register. If l<N-1, increment l -> ADDR; else -> WRITE.
  - WRITE: sram_we=1, sram_addr=a, sram_din=assembly register for exactly one cycle; clear the register; l=0. If a = K+N-2 -> DONE, else a+1 -> ADDR.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timing: 2N+1 = 33 cycles per word, 527*33 = 17391 cycles from start to the last sram_we; done follows 1 cycle later.
- start while busy is ignored. start in the same cycle as rst is ignored (rst wins).
- sram_we is never asserted outside WRITE. mem_read_enb is never low for an invalid lane.

Optional Feature:
- Macro: SKEW_LOADER_WORD_CACHE_EN.
- Defined:
  - Each lane keeps a 64-bit cached word, its address, and a valid flag; the valid flags clear on start.
  - A valid lane whose computed address equals its cached address skips ADDR: DATA takes the byte from the cache and no read is issued.
  - Invalid lanes also skip ADDR (1 cycle).
  - Fetched words update that lane's cache.
  - mode 0 then issues exactly K/8 = 64 reads per lane.
- Undefined: fixed 2-cycle-per-lane timing as above. SRAM contents are identical in both builds.

Test Plan:
- Memory model: mem[x] byte lane 7-m = (x*8+m) & 0xFF.
- mode=0, tile_idx=0, base_addr=0:
  - word 0 = lane0 0x00, lanes 1-15 0x00.
  - word 5: lane l = 5-l for l<=5, 0 above.
  - word 526: lane15 = 0xFF, rest 0.
  - exactly 527 sram_we pulses; done at cycle 17392 (non-cache build).
- mode=1, tile_idx=1, base_addr=0x8000:
  - word 0 lane0 reads address 0x8002, byte lane 7, value 0x10.
  - word 1 lane1 = k0 of column 17, value 0x11.
- Assert rst at cycle 500 of a load: the next cycle shows all outputs at reset values and no sram_we. A subsequent start completes normally.
- start pulsed again during a load: ignored; sram_we count stays 527 and a single done pulse is seen.
- Padding check: across all invalid lanes, mem_read_enb is never 0. Non-cache build: exactly 512*16 = 8192 read strobes total.
- SKEW_LOADER_WORD_CACHE_EN with mode=0: 64*16 = 1024 read strobes; SRAM contents match the non-cache run word-for-word.
